reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer.sv | 186 ++++++++++++++++++
 tb/tb_reorder_buffer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer
// Purpose  : Per-tag packet store released in tag order under head verdicts.
//            Optional head timeout enabled by macro REORDER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
    parameter int TAG_WIDTH  = 6,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BEATS  = 256,
    parameter int CNT_WIDTH  = 16
`ifdef REORDER_TIMEOUT_EN
    ,parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_tdata,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    input  logic                  in_tlast,
    input  logic                  in_tvalid,
    output logic                  in_tready,
    output logic [TAG_WIDTH-1:0]  head_tag,
    input  logic [1:0]            head_status,
    output logic [DATA_WIDTH-1:0] out_tdata,
    output logic                  out_tlast,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic [TAG_WIDTH:0]    occupancy,
    output logic [CNT_WIDTH-1:0]  sent_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    output logic [CNT_WIDTH-1:0]  trunc_cnt
);
    localparam int NUM_SLOTS = 2**TAG_WIDTH;
    localparam int c_BEAT_W  = $clog2(MAX_BEATS);
    localparam logic [1:0] c_FREE    = 2'd0;
    localparam logic [1:0] c_FILLING = 2'd1;
    localparam logic [1:0] c_FULL    = 2'd2;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_DROP = 2'd2} state_t;
    state_t r_state, w_state_nxt;

    logic [1:0]            r_slot_st    [NUM_SLOTS];
    logic [c_BEAT_W:0]     r_slot_cnt   [NUM_SLOTS];
    logic                  r_slot_trunc [NUM_SLOTS];
    logic [DATA_WIDTH-1:0] r_mem        [NUM_SLOTS*MAX_BEATS];

    logic [TAG_WIDTH-1:0]  r_head;
    logic [c_BEAT_W:0]     r_rd_idx;
    logic                  r_out_valid, r_out_last;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [TAG_WIDTH:0]    r_occ;
    logic [CNT_WIDTH-1:0]  r_sent, r_drop, r_trunc;

    logic              w_accept, w_in_room, w_head_full, w_done, w_load;
    logic              w_release, w_occ_inc, w_trunc_pkt, w_timeout;
    logic [c_BEAT_W:0] w_in_cnt, w_head_cnt;

    assign w_accept    = in_tvalid & in_tready;
    assign w_in_cnt    = r_slot_cnt[in_tag];
    // Count saturates at MAX_BEATS (a power of two), so the top bit means "slot full of beats".
    assign w_in_room   = ~w_in_cnt[c_BEAT_W];
    assign w_head_full = (r_slot_st[r_head] == c_FULL);
    assign w_head_cnt  = r_slot_cnt[r_head];
    assign w_done      = (r_state == S_SEND) & r_out_valid & out_tready & r_out_last;
    assign w_load      = (r_state == S_SEND) & (~r_out_valid | out_tready) & (r_rd_idx < w_head_cnt);
    assign w_release   = w_done | (r_state == S_DROP);
    assign w_occ_inc   = w_accept & (r_slot_st[in_tag] == c_FREE);
    assign w_trunc_pkt = w_accept & in_tlast & (r_slot_trunc[in_tag] | ~w_in_room);

    assign in_tready  = ~rst | (r_slot_st[in_tag] != c_FULL);
    assign head_tag   = rst ? r_head : '0;
    assign out_tvalid = r_out_valid & rst;
    assign out_tlast  = r_out_last & rst;
    assign out_tdata  = r_out_data;
    assign occupancy  = r_occ;
    assign sent_cnt   = r_sent;
    assign drop_cnt   = r_drop;
    assign trunc_cnt  = r_trunc;

`ifdef REORDER_TIMEOUT_EN
    logic [31:0] r_to_cnt;
    logic        w_pending;
    assign w_pending = (r_state == S_IDLE) & w_head_full & (head_status != 2'b11) & (head_status != 2'b01);
    assign w_timeout = w_pending & (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst || w_release) begin
            r_to_cnt <= '0;
        end else if (w_pending && r_to_cnt != 32'(TIMEOUT_CYCLES)) begin
            r_to_cnt <= r_to_cnt + 32'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_head_full) begin
                    if (head_status == 2'b11)                    w_state_nxt = S_SEND;
                    else if (head_status == 2'b01 || w_timeout)  w_state_nxt = S_DROP;
                end
            end
            S_SEND:  if (w_done) w_state_nxt = S_IDLE;
            S_DROP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Input writes only touch non-FULL slots and releases only FULL ones, so indices never collide.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_slot_st[i]    <= c_FREE;
                r_slot_cnt[i]   <= '0;
                r_slot_trunc[i] <= 1'b0;
            end
        end else begin
            if (w_accept) begin
                if (w_in_room) r_slot_cnt[in_tag]   <= w_in_cnt + 1'b1;
                else           r_slot_trunc[in_tag] <= 1'b1;
                r_slot_st[in_tag] <= in_tlast ? c_FULL : c_FILLING;
            end
            if (w_release) begin
                r_slot_st[r_head]    <= c_FREE;
                r_slot_cnt[r_head]   <= '0;
                r_slot_trunc[r_head] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head  <= '0;
            r_occ   <= '0;
            r_sent  <= '0;
            r_drop  <= '0;
            r_trunc <= '0;
        end else begin
            if (w_release) r_head <= r_head + 1'b1;
            case ({w_occ_inc, w_release})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
            if (w_done && !(&r_sent))                 r_sent  <= r_sent + 1'b1;
            if (r_state == S_DROP && !(&r_drop))      r_drop  <= r_drop + 1'b1;
            if (w_trunc_pkt && !(&r_trunc))           r_trunc <= r_trunc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_rd_idx    <= '0;
        end else if (r_state != S_SEND) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_rd_idx    <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_last  <= ((r_rd_idx + 1'b1) == w_head_cnt);
            r_rd_idx    <= r_rd_idx + 1'b1;
        end else if (r_out_valid && out_tready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && w_in_room) r_mem[{in_tag, w_in_cnt[c_BEAT_W-1:0]}] <= in_tdata;
        if (w_load)                r_out_data <= r_mem[{r_head, r_rd_idx[c_BEAT_W-1:0]}];
    end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reorder_buffer
// Purpose  : Randomized and directed bench for reorder_buffer with a
//            queue-based release model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] in_tdata = '0;
    logic [5:0]  in_tag = '0;
    logic        in_tlast = 1'b0, in_tvalid = 1'b0, in_tready;
    logic [5:0]  head_tag;
    logic [1:0]  head_status;
    logic [63:0] out_tdata;
    logic        out_tlast, out_tvalid;
    logic        out_tready = 1'b1;
    logic [6:0]  occupancy;
    logic [15:0] sent_cnt, drop_cnt, trunc_cnt;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .in_tdata(in_tdata), .in_tag(in_tag), .in_tlast(in_tlast),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .head_tag(head_tag),
        .head_status(head_status), .out_tdata(out_tdata), .out_tlast(out_tlast),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .occupancy(occupancy),
        .sent_cnt(sent_cnt), .drop_cnt(drop_cnt), .trunc_cnt(trunc_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Verdict table presented to the DUT for whatever tag it exposes as head.
    logic [1:0] verdict [64];
    logic       known   [64];
    assign head_status = known[head_tag] ? verdict[head_tag] : 2'b00;

    // Reference model: stored beats per tag plus the expected output stream.
    logic [63:0] m_mem [64][256];
    int          m_len [64];
    bit          m_full[64], m_used[64];
    int          m_head, m_sent, m_drop, m_trunc;
    logic [63:0] e_d[$], rx_d[$];
    logic        e_l[$], rx_l[$];

    int  rdy_mode = 0;
    bit  gaps = 0;
    bit  mon_en = 0;

    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0:       out_tready = 1'b1;
            1:       out_tready = ~out_tready;
            default: out_tready = 1'($urandom_range(0, 1));
        endcase
    end

    logic        prev_stall = 1'b0, prev_l;
    logic [63:0] prev_d;
    always @(negedge clk) begin
        if (!mon_en) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check_eq("stall_hold", {31'd0, out_tvalid, out_tlast, out_tdata}, {31'd0, 1'b1, prev_l, prev_d});
            if (out_tvalid && out_tready) begin
                rx_d.push_back(out_tdata);
                rx_l.push_back(out_tlast);
            end
            prev_stall = out_tvalid && !out_tready;
            prev_d     = out_tdata;
            prev_l     = out_tlast;
        end
    end

    task automatic clr_q();
        e_d.delete(); e_l.delete(); rx_d.delete(); rx_l.delete();
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) begin
            m_full[i] = 0; m_used[i] = 0; m_len[i] = 0; known[i] = 1'b0; verdict[i] = 2'b00;
        end
        m_head = 0; m_sent = 0; m_drop = 0; m_trunc = 0;
        clr_q();
    endtask

    task automatic do_reset();
        mon_en = 0; in_tvalid = 1'b0; in_tlast = 1'b0; rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_clear();
        mon_en = 1;
    endtask

    task automatic send_pkt(input int tag, input int n, input logic [1:0] v, input logic kn);
        logic [63:0] d;
        logic        rdy;
        int          w;
        verdict[tag] = v;
        known[tag]   = kn;
        for (int b = 0; b < n; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_tvalid = 1'b0;
                @(posedge clk); #1;
            end
            d = {$urandom, $urandom};
            in_tvalid = 1'b1; in_tag = 6'(tag); in_tdata = d; in_tlast = (b == n - 1);
            w = 0;
            do begin
                @(negedge clk); rdy = in_tready;
                @(posedge clk); #1; w++;
            end while (!rdy && w < 3000);
            if (!rdy) check_eq("in_ready_timeout", 96'd0, 96'd1);
            if (b < 256) m_mem[tag][b] = d;
        end
        in_tvalid = 1'b0; in_tlast = 1'b0;
        m_used[tag] = 1; m_full[tag] = 1;
        m_len[tag]  = (n > 256) ? 256 : n;
        if (n > 256) m_trunc++;
    endtask

    // Releases proceed strictly in tag order from the head while the head slot is complete and judged.
    task automatic model_release();
        while (m_full[m_head] && known[m_head]) begin
            if (verdict[m_head] == 2'b11) begin
                for (int b = 0; b < m_len[m_head]; b++) begin
                    e_d.push_back(m_mem[m_head][b]);
                    e_l.push_back(b == m_len[m_head] - 1);
                end
                m_sent++;
            end else begin
                m_drop++;
            end
            m_full[m_head] = 0; m_used[m_head] = 0;
            m_head = (m_head + 1) % 64;
        end
    endtask

    task automatic drain_check(input string nm);
        int w = 0;
        int used = 0;
        model_release();
        while (rx_d.size() < e_d.size() && w < 20000) begin
            @(posedge clk); #1; w++;
        end
        repeat (8) @(posedge clk);
        #1;
        check_eq({nm, "_nbeats"}, 96'(rx_d.size()), 96'(e_d.size()));
        for (int i = 0; i < e_d.size() && i < rx_d.size(); i++)
            check_eq({nm, "_beat"}, {31'd0, rx_l[i], rx_d[i]}, {31'd0, e_l[i], e_d[i]});
        for (int i = 0; i < 64; i++) used += m_used[i];
        check_eq({nm, "_sent"}, 96'(sent_cnt), 96'(m_sent));
        check_eq({nm, "_drop"}, 96'(drop_cnt), 96'(m_drop));
        check_eq({nm, "_trunc"}, 96'(trunc_cnt), 96'(m_trunc));
        check_eq({nm, "_head"}, 96'(head_tag), 96'(m_head));
        check_eq({nm, "_occ"}, 96'(occupancy), 96'(used));
    endtask

    initial begin
        int          k, base, t, w;
        int          order[$];
        logic [5:0]  lv;
        logic        seen;

        model_clear();
        do_reset();
        check_eq("rst_tvalid", 96'(out_tvalid), 96'd0);
        check_eq("rst_tlast", 96'(out_tlast), 96'd0);
        check_eq("rst_tready", 96'(in_tready), 96'd1);
        check_eq("rst_head", 96'(head_tag), 96'd0);
        check_eq("rst_occ", 96'(occupancy), 96'd0);
        check_eq("rst_cnts", {48'd0, sent_cnt, drop_cnt, trunc_cnt}, 96'd0);

        // Three in-order packets, all accepted.
        send_pkt(0, 3, 2'b11, 1'b1);
        send_pkt(1, 1, 2'b11, 1'b1);
        send_pkt(2, 2, 2'b11, 1'b1);
        drain_check("inorder");
        lv = '0;
        for (int i = 0; i < 6 && i < rx_l.size(); i++) lv[i] = rx_l[i];
        check_eq("inorder_tlast_pos", 96'(lv), 96'(6'b101100));

        // Out-of-order arrival with the head packet rejected.
        do_reset();
        send_pkt(2, 4, 2'b11, 1'b1);
        send_pkt(0, 2, 2'b01, 1'b1);
        send_pkt(1, 3, 2'b11, 1'b1);
        drain_check("reject");

        // Oversized packet truncated to MAX_BEATS.
        do_reset();
        for (int i = 0; i < 5; i++) send_pkt(i, 1, 2'b01, 1'b1);
        send_pkt(5, 300, 2'b11, 1'b1);
        drain_check("trunc");
        check_eq("trunc_nbeats", 96'(rx_d.size()), 96'd256);

        // Fill every slot with pending verdicts, then release all and reuse tag 0.
        do_reset();
        for (int i = 0; i < 64; i++) send_pkt(i, 1 + (i % 3), 2'b11, 1'b0);
        @(posedge clk); #1;
        check_eq("full_occ", 96'(occupancy), 96'd64);
        for (int i = 0; i < 64; i++) begin
            in_tag = 6'(i); #1;
            check_eq("full_tready", 96'(in_tready), 96'd0);
        end
        for (int i = 0; i < 64; i++) known[i] = 1'b1;
        rdy_mode = 1;
        drain_check("fullwrap");
        in_tag = 6'd0; #1;
        check_eq("wrap_tready0", 96'(in_tready), 96'd1);
        clr_q();
        send_pkt(0, 5, 2'b11, 1'b1);
        drain_check("wrap_reuse");

        // Randomized rounds of consecutive tags written in shuffled order.
        for (int r = 0; r < 12; r++) begin
            clr_q();
            rdy_mode = r % 3;
            gaps = (r % 2 == 1);
            k = $urandom_range(1, 8);
            base = m_head;
            order.delete();
            for (int i = 0; i < k; i++) order.push_back((base + i) % 64);
            order.shuffle();
            foreach (order[i]) begin
                t = order[i];
                send_pkt(t, $urandom_range(1, 24), ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b11, 1'b1);
            end
            drain_check("random");
        end
        rdy_mode = 0; gaps = 0;

        // Reset while tag 4 is streaming out.
        do_reset();
        for (int i = 0; i < 4; i++) send_pkt(i, 1, 2'b01, 1'b1);
        send_pkt(4, 40, 2'b11, 1'b1);
        w = 0;
        while (!out_tvalid && w < 100) begin @(posedge clk); #1; w++; end
        check_eq("midsend_active", 96'(out_tvalid), 96'd1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("midsend_drop", 96'(drop_cnt), 96'd4);
        mon_en = 0; rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        check_eq("postrst_tvalid", 96'(out_tvalid), 96'd0);
        check_eq("postrst_occ", 96'(occupancy), 96'd0);
        check_eq("postrst_cnts", {48'd0, sent_cnt, drop_cnt, trunc_cnt}, 96'd0);
        check_eq("postrst_head", 96'(head_tag), 96'd0);
        model_clear();
        seen = 1'b0;
        repeat (60) begin @(negedge clk); seen |= out_tvalid; end
        @(posedge clk); #1;
        check_eq("postrst_quiet", 96'(seen), 96'd0);

`ifdef REORDER_TIMEOUT_EN
        do_reset();
        send_pkt(0, 2, 2'b11, 1'b0);
        repeat (1100) @(posedge clk);
        #1;
        check_eq("timeout_drop", 96'(drop_cnt), 96'd1);
        check_eq("timeout_head", 96'(head_tag), 96'd1);
        check_eq("timeout_occ", 96'(occupancy), 96'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "simulation time limit reached");
    end
endmodule
`default_nettype wire
